dtc_share_sched: RTL and testbench

- Round-robin scheduler that shares one combinational decision-tree classifier instance (8-bit feature in, 2-bit class out) between NREQ requesters.
- Each requester presents a feature vector on a valid/ready handshake. The block grants one requester at a time and drives the registered feature into the classifier.
- It captures the class one cycle later and returns it on a single tagged response channel with backpressure.
- Sits between the feature producers and the generated classifier in the inference datapath.

---
 rtl/dtc_share_sched.sv | 122 ++++++++++++
 tb/tb_dtc_share_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dtc_share_sched.sv
// Round-robin scheduler sharing one combinational decision-tree classifier
// between NREQ requesters, returning tagged class results with backpressure.
module dtc_share_sched #(
   parameter int NREQ   = 4,
   parameter int FEAT_W = 8,
   parameter int CLS_W  = 2,
   parameter int ID_W   = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*FEAT_W-1:0] req_feat,
   output logic [NREQ-1:0]        req_ready,
   output logic [FEAT_W-1:0]      cls_feat,
   input  logic [CLS_W-1:0]       cls_class,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [CLS_W-1:0]       rsp_class,
   output logic                   busy,
   output logic [15:0]            done_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic [ID_W-1:0]     ptr_r;
   logic [ID_W-1:0]     id_r;
   logic [FEAT_W-1:0]   feat_r;
   logic                rsp_valid_r;
   logic [ID_W-1:0]     rsp_id_r;
   logic [CLS_W-1:0]    rsp_class_r;
   logic [15:0]         done_cnt_r;

   logic                found_s;
   logic [ID_W-1:0]     grant_s;
   logic [FEAT_W-1:0]   feat_sel_s;
   logic [NREQ-1:0]     req_ready_s;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      found_s    = 1'b0;
      grant_s    = '0;
      feat_sel_s = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(ptr_r) + k) % NREQ;
         if (!found_s && req_valid[idx]) begin
            found_s    = 1'b1;
            grant_s    = ID_W'(idx);
            feat_sel_s = req_feat[idx*FEAT_W +: FEAT_W];
         end else begin
            found_s    = found_s;
         end
      end
   end

   // One-hot accept, only offered while idle
   always_comb begin
      req_ready_s = '0;
      if (state_r == IDLE && found_s) begin
         req_ready_s[grant_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   // Scheduler FSM: grant, evaluate for one cycle, hold the response until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ptr_r       <= ID_W'(NREQ - 1);
         id_r        <= '0;
         feat_r      <= '0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_class_r <= '0;
         done_cnt_r  <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  feat_r  <= feat_sel_s;
                  id_r    <= grant_s;
                  ptr_r   <= grant_s;
                  state_r <= EVAL;
               end
            end
            EVAL: begin
               rsp_class_r <= cls_class;
               rsp_id_r    <= id_r;
               rsp_valid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  done_cnt_r  <= done_cnt_r + 16'd1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_s;
   assign cls_feat  = feat_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_class = rsp_class_r;
   assign busy      = (state_r != IDLE);
   assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_dtc_share_sched.sv
// Table-driven bench for dtc_share_sched with a stub classifier
// (class = feat[1:0] ^ feat[7:6]) and a hand-written counter-wrap sequence.
module tb_dtc_share_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_feat;
   logic [3:0]  req_ready;
   logic [7:0]  cls_feat;
   logic [1:0]  cls_class;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [1:0]  rsp_class;
   logic        busy;
   logic [15:0] done_cnt;

   int checks   = 0;
   int failures = 0;

   dtc_share_sched #(.NREQ(4), .FEAT_W(8), .CLS_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_feat  (req_feat),
      .req_ready (req_ready),
      .cls_feat  (cls_feat),
      .cls_class (cls_class),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_class (rsp_class),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   assign cls_class = cls_feat[1:0] ^ cls_feat[7:6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  rv;
      logic [31:0] feat;
      logic        rr;
      logic [3:0]  rdy;
      logic [7:0]  cf;
      logic        v;
      logic [1:0]  id;
      logic [1:0]  cl;
      logic        b;
      logic [15:0] d;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic [3:0] rv, input logic [31:0] feat,
                      input logic rr, input logic [3:0] rdy, input logic [7:0] cf,
                      input logic v, input logic [1:0] id, input logic [1:0] cl,
                      input logic b, input logic [15:0] d);
      vec_t t;
      t.rst = rst; t.rv = rv; t.feat = feat; t.rr = rr; t.rdy = rdy; t.cf = cf;
      t.v = v; t.id = id; t.cl = cl; t.b = b; t.d = d;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
      end
   endtask

   // Request one transaction from requester rid and check its response and count
   task automatic serve(input int rid, input logic [7:0] f, input logic [1:0] ecl,
                        input logic [15:0] edone);
      int n;
      @(negedge clk);
      req_valid      = 4'b0000;
      req_valid[rid] = 1'b1;
      req_feat       = 32'd0;
      req_feat[rid*8 +: 8] = f;
      rsp_ready      = 1'b1;
      #1;
      n = 0;
      while (!req_ready[rid] && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("wrap_grant", rid, {31'd0, req_ready[rid]}, 32'd1);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      n = 0;
      while (!rsp_valid && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("wrap_rsp_valid", rid, {31'd0, rsp_valid}, 32'd1);
      chk("wrap_rsp_id", rid, {30'd0, rsp_id}, rid);
      chk("wrap_rsp_class", rid, {30'd0, rsp_class}, {30'd0, ecl});
      @(negedge clk);
      #1;
      chk("wrap_done_cnt", rid, {16'd0, done_cnt}, {16'd0, edone});
   endtask

   localparam logic [31:0] F1 = 32'h0000_0081;
   localparam logic [31:0] FA = 32'hC382_4100;
   localparam logic [31:0] FB = 32'hC001_8042;

   initial begin
      // rst  rv     feat rr  rdy     cf     v   id  cl  b   d
      add(0, 4'b0000, F1, 1, 4'b0000, 8'h00, 0, 0, 0, 0, 16'd0);
      add(0, 4'b0001, F1, 1, 4'b0001, 8'h00, 0, 0, 0, 0, 16'd0);
      add(0, 4'b0000, F1, 1, 4'b0000, 8'h81, 0, 0, 0, 1, 16'd0);
      add(0, 4'b0000, F1, 0, 4'b0000, 8'h81, 1, 0, 3, 1, 16'd0);
      add(0, 4'b0000, F1, 1, 4'b0000, 8'h81, 1, 0, 3, 1, 16'd0);
      add(0, 4'b0000, F1, 1, 4'b0000, 8'h81, 0, 0, 0, 0, 16'd1);
      add(0, 4'b1111, FA, 1, 4'b0010, 8'h81, 0, 0, 0, 0, 16'd1);
      add(1, 4'b1111, FA, 1, 4'b0000, 8'h41, 0, 0, 0, 1, 16'd1);
      add(0, 4'b1111, FA, 1, 4'b0001, 8'h00, 0, 0, 0, 0, 16'd0);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'h00, 0, 0, 0, 1, 16'd0);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'h00, 1, 0, 0, 1, 16'd0);
      add(0, 4'b1111, FA, 1, 4'b0010, 8'h00, 0, 0, 0, 0, 16'd1);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'h41, 0, 0, 0, 1, 16'd1);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'h41, 1, 1, 0, 1, 16'd1);
      add(0, 4'b1111, FA, 1, 4'b0100, 8'h41, 0, 0, 0, 0, 16'd2);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'h82, 0, 0, 0, 1, 16'd2);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'h82, 1, 2, 0, 1, 16'd2);
      add(0, 4'b1111, FA, 1, 4'b1000, 8'h82, 0, 0, 0, 0, 16'd3);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'hC3, 0, 0, 0, 1, 16'd3);
      add(0, 4'b1111, FA, 1, 4'b0000, 8'hC3, 1, 3, 0, 1, 16'd3);
      add(0, 4'b1111, FB, 1, 4'b0001, 8'hC3, 0, 0, 0, 0, 16'd4);
      add(0, 4'b1111, FB, 0, 4'b0000, 8'h42, 0, 0, 0, 1, 16'd4);
      for (int i = 0; i < 5; i++)
         add(0, 4'b1111, FB, 0, 4'b0000, 8'h42, 1, 0, 3, 1, 16'd4);
      add(0, 4'b1111, FB, 1, 4'b0000, 8'h42, 1, 0, 3, 1, 16'd4);
      add(0, 4'b1111, FB, 1, 4'b0010, 8'h42, 0, 0, 0, 0, 16'd5);
      add(0, 4'b1111, FB, 1, 4'b0000, 8'h80, 0, 0, 0, 1, 16'd5);
      add(0, 4'b1111, FB, 1, 4'b0000, 8'h80, 1, 1, 2, 1, 16'd5);
      add(0, 4'b0101, FB, 1, 4'b0100, 8'h80, 0, 0, 0, 0, 16'd6);
      add(0, 4'b0101, FB, 1, 4'b0000, 8'h01, 0, 0, 0, 1, 16'd6);
      add(0, 4'b0101, FB, 1, 4'b0000, 8'h01, 1, 2, 1, 1, 16'd6);
      add(0, 4'b0101, FB, 1, 4'b0001, 8'h01, 0, 0, 0, 0, 16'd7);
      add(0, 4'b0101, FB, 1, 4'b0000, 8'h42, 0, 0, 0, 1, 16'd7);
      add(0, 4'b0101, FB, 1, 4'b0000, 8'h42, 1, 0, 3, 1, 16'd7);
      add(0, 4'b0101, FB, 1, 4'b0100, 8'h42, 0, 0, 0, 0, 16'd8);
      add(0, 4'b0111, FB, 1, 4'b0000, 8'h01, 0, 0, 0, 1, 16'd8);
      add(0, 4'b0111, FB, 1, 4'b0000, 8'h01, 1, 2, 1, 1, 16'd8);
      add(0, 4'b0111, FB, 1, 4'b0001, 8'h01, 0, 0, 0, 0, 16'd9);
      add(0, 4'b0111, FB, 1, 4'b0000, 8'h42, 0, 0, 0, 1, 16'd9);
      add(0, 4'b0111, FB, 1, 4'b0000, 8'h42, 1, 0, 3, 1, 16'd9);
      add(0, 4'b0111, FB, 1, 4'b0010, 8'h42, 0, 0, 0, 0, 16'd10);
      add(0, 4'b0111, FB, 1, 4'b0000, 8'h80, 0, 0, 0, 1, 16'd10);
      add(0, 4'b0111, FB, 1, 4'b0000, 8'h80, 1, 1, 2, 1, 16'd10);
      add(0, 4'b0111, FB, 1, 4'b0100, 8'h80, 0, 0, 0, 0, 16'd11);
      add(0, 4'b0000, FB, 1, 4'b0000, 8'h01, 0, 0, 0, 1, 16'd11);
      add(0, 4'b0000, FB, 1, 4'b0000, 8'h01, 1, 2, 1, 1, 16'd11);
      add(0, 4'b0000, FB, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 16'd12);

      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_feat  = 32'd0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Inputs change mid-cycle; outputs are sampled 1 time unit later
      for (int r = 0; r < tbl.size(); r++) begin
         @(negedge clk);
         rst_n     = !tbl[r].rst;
         req_valid = tbl[r].rv;
         req_feat  = tbl[r].feat;
         rsp_ready = tbl[r].rr;
         #1;
         chk("req_ready", r, {28'd0, req_ready}, {28'd0, tbl[r].rdy});
         chk("cls_feat", r, {24'd0, cls_feat}, {24'd0, tbl[r].cf});
         chk("rsp_valid", r, {31'd0, rsp_valid}, {31'd0, tbl[r].v});
         chk("busy", r, {31'd0, busy}, {31'd0, tbl[r].b});
         chk("done_cnt", r, {16'd0, done_cnt}, {16'd0, tbl[r].d});
         if (tbl[r].v) begin
            chk("rsp_id", r, {30'd0, rsp_id}, {30'd0, tbl[r].id});
            chk("rsp_class", r, {30'd0, rsp_class}, {30'd0, tbl[r].cl});
         end
      end

      // Counter wrap: preload the completion count just below the limit
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'b0000;
      force dut.done_cnt_r = 16'hFFFE;
      @(negedge clk);
      release dut.done_cnt_r;
      #1;
      chk("wrap_preload", 0, {16'd0, done_cnt}, 32'h0000_FFFE);
      serve(0, 8'h03, 2'b11, 16'hFFFF);
      serve(1, 8'hC0, 2'b11, 16'h0000);
      serve(2, 8'h42, 2'b11, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
